// File: rtl/dot_product_accumulator.sv
// Dot-product accumulator: sums LEN consecutive unsigned products from the
// upstream multiplier and presents each sum with a sticky wrap flag on a
// valid/ready output. A result can drain in the same cycle the next vector's
// first product is taken, so a stream runs at one product per cycle.
module dot_product_accumulator #(
    parameter int unsigned LEN   = 4,
    parameter int unsigned ACC_W = 12,
    localparam int unsigned CNT_W = $clog2(LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       prod_i,
    input  logic             prod_valid_i,
    output logic             prod_ready_o,
    input  logic             clear_i,
    output logic [ACC_W-1:0] acc_o,
    output logic             acc_valid_o,
    input  logic             acc_ready_i,
    output logic             ovf_o,
    output logic [CNT_W-1:0] cnt_o
);

    localparam int unsigned SUM_W = ACC_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

    typedef enum logic [0:0] {StAccum, StHold} state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W-1:0]   res_q, res_d;
    logic               res_ovf_q, res_ovf_d;

    logic               accept;
    logic               drain;
    logic               last;
    logic [SUM_W-1:0]   sum;

    // Handshake view and the running sum with its carry out.
    always_comb begin
        acc_valid_o  = (state_q == StHold);
        // While holding, a new product may only enter as the result leaves.
        prod_ready_o = (state_q == StAccum) ? 1'b1 : acc_ready_i;
        accept       = prod_valid_i & prod_ready_o;
        drain        = acc_valid_o & acc_ready_i;
        last         = (cnt_q == LAST_CNT);
        sum          = {1'b0, acc_q} + SUM_W'(prod_i);
        acc_o        = res_q;
        ovf_o        = res_ovf_q;
        cnt_o        = cnt_q;
    end

    // Next-state logic; clear wins over both handshakes.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        res_d     = res_q;
        res_ovf_d = res_ovf_q;

        if (clear_i) begin
            state_d = StAccum;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            if (drain) begin
                state_d = StAccum;
            end
            // In HOLD the partial registers are already zero, so the same
            // path starts the next vector when a product rides the drain.
            if (accept) begin
                if (last) begin
                    res_d     = sum[ACC_W-1:0];
                    res_ovf_d = ovf_q | sum[ACC_W];
                    acc_d     = '0;
                    cnt_d     = '0;
                    ovf_d     = 1'b0;
                    state_d   = StHold;
                end else begin
                    acc_d = sum[ACC_W-1:0];
                    ovf_d = ovf_q | sum[ACC_W];
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StAccum;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            res_q     <= '0;
            res_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            res_q     <= res_d;
            res_ovf_q <= res_ovf_d;
        end
    end

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Directed bench for dot_product_accumulator. Two instances share stimulus:
// one at ACC_W=12 (no wrap possible) and one at ACC_W=9 to exercise wrap.
module tb_dot_product_accumulator;

    logic        clk;
    logic        rst;
    logic [7:0]  prod_i;
    logic        prod_valid_i;
    logic        clear_i;
    logic        acc_ready_i;

    logic        prod_ready_o, prod_ready9;
    logic [11:0] acc_o;
    logic [8:0]  acc9;
    logic        acc_valid_o, acc_valid9;
    logic        ovf_o, ovf9;
    logic [2:0]  cnt_o, cnt9;

    int checks = 0;
    int errors = 0;
    int exp_res[3] = '{10, 26, 42};

    dot_product_accumulator #(.LEN(4), .ACC_W(12)) dut (
        .clk          (clk),
        .rst          (rst),
        .prod_i       (prod_i),
        .prod_valid_i (prod_valid_i),
        .prod_ready_o (prod_ready_o),
        .clear_i      (clear_i),
        .acc_o        (acc_o),
        .acc_valid_o  (acc_valid_o),
        .acc_ready_i  (acc_ready_i),
        .ovf_o        (ovf_o),
        .cnt_o        (cnt_o)
    );

    dot_product_accumulator #(.LEN(4), .ACC_W(9)) dut9 (
        .clk          (clk),
        .rst          (rst),
        .prod_i       (prod_i),
        .prod_valid_i (prod_valid_i),
        .prod_ready_o (prod_ready9),
        .clear_i      (clear_i),
        .acc_o        (acc9),
        .acc_valid_o  (acc_valid9),
        .acc_ready_i  (acc_ready_i),
        .ovf_o        (ovf9),
        .cnt_o        (cnt9)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] v);
        prod_valid_i = 1'b1;
        prod_i       = v;
        @(posedge clk);
        #1;
        prod_valid_i = 1'b0;
        prod_i       = 8'h00;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        prod_i       = 8'h00;
        prod_valid_i = 1'b0;
        clear_i      = 1'b0;
        acc_ready_i  = 1'b1;
        #22;
        chk("rst_acc", 32'(acc_o), 0);
        chk("rst_valid", 32'(acc_valid_o), 0);
        chk("rst_ovf", 32'(ovf_o), 0);
        chk("rst_cnt", 32'(cnt_o), 0);
        rst = 1'b0;
        #1;
        chk("rst_ready", 32'(prod_ready_o), 1);
        tick();

        // 4 x 225 back-to-back: 900 fits 12 bits, wraps to 388 in 9 bits.
        push(8'd225);
        push(8'd225);
        push(8'd225);
        chk("t1_cnt3", 32'(cnt_o), 3);
        chk("t1_valid_early", 32'(acc_valid_o), 0);
        push(8'd225);
        chk("t1_valid", 32'(acc_valid_o), 1);
        chk("t1_acc", 32'(acc_o), 900);
        chk("t1_ovf", 32'(ovf_o), 0);
        chk("t1_acc9", 32'(acc9), 388);
        chk("t1_ovf9", 32'(ovf9), 1);
        tick();
        chk("t1_valid_1cyc", 32'(acc_valid_o), 0);

        // Next vector clears the sticky flag.
        push(8'd1);
        push(8'd2);
        push(8'd3);
        push(8'd4);
        chk("t2_acc", 32'(acc_o), 10);
        chk("t2_acc9", 32'(acc9), 10);
        chk("t2_ovf9", 32'(ovf9), 0);
        tick();

        // Backpressure, then drain with a simultaneous first product.
        acc_ready_i = 1'b0;
        push(8'd5);
        push(8'd6);
        push(8'd7);
        push(8'd8);
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_valid", 32'(acc_valid_o), 1);
            chk("t3_hold_acc", 32'(acc_o), 26);
            chk("t3_hold_ovf", 32'(ovf_o), 0);
            chk("t3_hold_ready", 32'(prod_ready_o), 0);
            tick();
        end
        acc_ready_i  = 1'b1;
        prod_valid_i = 1'b1;
        prod_i       = 8'd9;
        #1;
        chk("t3_ready_comb", 32'(prod_ready_o), 1);
        tick();
        prod_valid_i = 1'b0;
        chk("t3_drained", 32'(acc_valid_o), 0);
        chk("t3_cnt1", 32'(cnt_o), 1);
        push(8'd1);
        push(8'd1);
        push(8'd1);
        chk("t3_acc_next", 32'(acc_o), 12);
        chk("t3_valid_next", 32'(acc_valid_o), 1);

        // Continuous stream 1..12 with no bubble.
        for (int i = 1; i <= 12; i++) begin
            prod_valid_i = 1'b1;
            prod_i       = 8'(i);
            #1;
            chk("t4_no_bubble", 32'(prod_ready_o), 1);
            tick();
            if (i % 4 == 0) begin
                chk("t4_valid", 32'(acc_valid_o), 1);
                chk("t4_acc", 32'(acc_o), 32'(exp_res[i/4-1]));
            end else begin
                chk("t4_idle", 32'(acc_valid_o), 0);
            end
        end
        prod_valid_i = 1'b0;
        tick();

        // Clear mid-vector drops the product in the clear cycle.
        push(8'd49);
        push(8'd36);
        chk("t5_cnt2", 32'(cnt_o), 2);
        clear_i      = 1'b1;
        prod_valid_i = 1'b1;
        prod_i       = 8'd100;
        tick();
        clear_i      = 1'b0;
        prod_valid_i = 1'b0;
        chk("t5_clr_cnt", 32'(cnt_o), 0);
        chk("t5_clr_valid", 32'(acc_valid_o), 0);
        push(8'd1);
        push(8'd1);
        push(8'd1);
        push(8'd1);
        chk("t5_acc", 32'(acc_o), 4);
        chk("t5_valid", 32'(acc_valid_o), 1);

        // Clear while holding discards the pending result.
        acc_ready_i = 1'b0;
        clear_i     = 1'b1;
        tick();
        clear_i = 1'b0;
        chk("t5_clr_hold", 32'(acc_valid_o), 0);
        acc_ready_i = 1'b1;

        // Async reset mid-vector, with a wrapped result still on ovf9.
        acc_ready_i = 1'b0;
        push(8'd225);
        push(8'd225);
        push(8'd225);
        push(8'd225);
        chk("t6_ovf9_set", 32'(ovf9), 1);
        acc_ready_i = 1'b1;
        push(8'd10);
        push(8'd20);
        push(8'd30);
        chk("t6_cnt3", 32'(cnt_o), 3);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(acc_valid_o), 0);
        chk("t6_rst_cnt", 32'(cnt_o), 0);
        chk("t6_rst_ovf9", 32'(ovf9), 0);
        chk("t6_rst_acc9", 32'(acc9), 0);
        #1;
        rst = 1'b0;
        tick();
        push(8'd64);
        push(8'd64);
        push(8'd64);
        push(8'd64);
        chk("t6_acc", 32'(acc_o), 256);
        chk("t6_acc9", 32'(acc9), 256);
        chk("t6_valid", 32'(acc_valid_o), 1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
